// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad event controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        StDrive,
        StSample,
        StEval
    } scan_state_e;

    // Event word layout: key code in [kw-1:0], release flag directly above it.
    function automatic int unsigned rel_flag_pos(input int unsigned kw);
        return kw;
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Show-ahead event FIFO; a pop frees room for a same-cycle push when full.
module keypad_evt_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Matrix keypad scanner with per-key debounce and an event FIFO.
// Define KEYPAD_RELEASE_EVT_EN to also queue key-release events.
module keypad_event_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned SETTLE     = 16,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned KW = $clog2(ROWS * COLS),
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLS-1:0]      col_n,
    output logic [ROWS-1:0]      row_n,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 evt_valid,
    output logic [KW:0]          evt_data,
    input  logic                 evt_pop,
    output logic [CW-1:0]        evt_count,
    output logic                 irq,
    output logic                 overflow,
    input  logic                 ovf_clear
);

    localparam int unsigned NK     = ROWS * COLS;
    localparam int unsigned RowW   = $clog2(ROWS);
    localparam int unsigned ColW   = $clog2(COLS);
    localparam int unsigned TmrMax = (SETTLE > COLS) ? SETTLE : COLS;
    localparam int unsigned TW     = $clog2(TmrMax);
    localparam int unsigned DbW    = $clog2(DEBOUNCE + 1);
    localparam int unsigned RelPos = rel_flag_pos(KW);
`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit RelEvtEn = 1'b1;
`else
    localparam bit RelEvtEn = 1'b0;
`endif

    scan_state_e      state_q, state_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [COLS-1:0]  sync1_q, sync2_q, samp_q;
    logic [NK-1:0]    key_q, key_d;
    logic [DbW-1:0]   dbc_q [NK];
    logic [DbW-1:0]   dbc_d [NK];
    logic             ovf_q, ovf_d;

    logic [ColW-1:0]  col_idx;
    logic [KW-1:0]    key_idx;
    logic             hit, evt_gen, evt_rel, evt_push, ovf_set;
    logic [KW:0]      evt_word;
    logic             fifo_full, fifo_empty;

    // Scan FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StDrive;
            row_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            tmr_q   <= tmr_d;
        end
    end

    // Scan FSM: next state; tmr_q counts settle cycles in DRIVE and columns in EVAL
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            StDrive: begin
                if (tmr_q == TW'(SETTLE - 1)) begin
                    state_d = StSample;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StSample: begin
                state_d = StEval;
                tmr_d   = '0;
            end
            StEval: begin
                if (tmr_q == TW'(COLS - 1)) begin
                    state_d = StDrive;
                    tmr_d   = '0;
                    row_d   = (row_q == RowW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = StDrive;
                row_d   = '0;
                tmr_d   = '0;
            end
        endcase
    end

    // Scan FSM: outputs
    always_comb begin
        row_n = '1;
        if (!rst && state_q != StEval) begin
            row_n[row_q] = 1'b0;
        end
    end

    always_comb begin
        key_d    = key_q;
        dbc_d    = dbc_q;
        evt_gen  = 1'b0;
        evt_rel  = 1'b0;
        col_idx  = tmr_q[ColW-1:0];
        key_idx  = KW'(int'(row_q) * int'(COLS) + int'(col_idx));
        hit      = ~samp_q[col_idx];
        if (state_q == StEval) begin
            if (hit != key_q[key_idx]) begin
                if (dbc_q[key_idx] == DbW'(DEBOUNCE - 1)) begin
                    key_d[key_idx] = hit;
                    dbc_d[key_idx] = '0;
                    evt_gen        = 1'b1;
                    evt_rel        = ~hit;
                end else begin
                    dbc_d[key_idx] = dbc_q[key_idx] + 1'b1;
                end
            end else begin
                dbc_d[key_idx] = '0;
            end
        end
    end

    always_comb begin
        evt_word              = '0;
        evt_word[KW-1:0]      = key_idx;
        evt_word[RelPos]      = evt_rel;
        evt_push              = evt_gen && (!evt_rel || RelEvtEn);
        // A full FIFO always has a head, so any pop makes room for this push.
        ovf_set               = evt_push && fifo_full && !evt_pop;
        ovf_d                 = ovf_set || (ovf_q && !ovf_clear);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            key_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NK; i++) begin
                dbc_q[i] <= '0;
            end
        end else begin
            sync1_q <= col_n;
            sync2_q <= sync1_q;
            if (state_q == StSample) begin
                samp_q <= sync2_q;
            end
            key_q <= key_d;
            dbc_q <= dbc_d;
            ovf_q <= ovf_d;
        end
    end

    keypad_evt_fifo #(
        .WIDTH (KW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (evt_push),
        .data_i  (evt_word),
        .pop_i   (evt_pop),
        .data_o  (evt_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (evt_count)
    );

    assign key_state = key_q;
    assign evt_valid = !fifo_empty;
    assign overflow  = ovf_q;
    assign irq       = evt_valid || ovf_q;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Scoreboard bench for keypad_event_ctrl: scan-level reference model plus queued expected events.
module tb_keypad_event_ctrl;

    localparam int unsigned Deb   = 3;
    localparam int unsigned Depth = 4;
`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit RelEn = 1'b1;
`else
    localparam bit RelEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] key_state;
    logic        evt_valid;
    logic [4:0]  evt_data;
    logic        evt_pop;
    logic [2:0]  evt_count;
    logic        irq;
    logic        overflow;
    logic        ovf_clear = 1'b0;

    logic        mon_pop  = 1'b0;
    logic        man_pop  = 1'b0;
    logic        auto_pop = 1'b0;
    logic [15:0] pressed  = '0;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state: debounced bitmap, per-key run lengths, expected events
    logic [15:0] m_stable = '0;
    int          m_cnt [16];
    int          m_drop = 0;
    logic [4:0]  sb_q [$];

    assign evt_pop = mon_pop | man_pop;

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its column to its row
    always_comb begin
        col_n = '1;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    keypad_event_ctrl #(
        .ROWS       (4),
        .COLS       (4),
        .SETTLE     (3),
        .DEBOUNCE   (Deb),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_state (key_state),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_pop   (evt_pop),
        .evt_count (evt_count),
        .irq       (irq),
        .overflow  (overflow),
        .ovf_clear (ovf_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each key is sampled once per scan; DEBOUNCE differing scans in a row flip it.
    task automatic model_scan(input logic [15:0] pat);
        for (int k = 0; k < 16; k++) begin
            if (pat[k] != m_stable[k]) begin
                m_cnt[k]++;
                if (m_cnt[k] == Deb) begin
                    m_stable[k] = pat[k];
                    m_cnt[k]    = 0;
                    if (pat[k] || RelEn) begin
                        if (!auto_pop && sb_q.size() >= Depth) m_drop++;
                        else sb_q.push_back({~pat[k], 4'(k)});
                    end
                end
            end else begin
                m_cnt[k] = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_stable = '0;
        for (int k = 0; k < 16; k++) m_cnt[k] = 0;
        sb_q.delete();
    endtask

    task automatic wait_row(input logic [3:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (row_n !== v && n < 100);
        if (row_n !== v) begin
            n_checks++;
            n_errs++;
            $display("FAIL wait_row: got %0h expected %0h", row_n, v);
        end
    endtask

    // Apply pat while row 3 is being evaluated so the whole next scan sees it.
    task automatic run_scan(input logic [15:0] pat);
        wait_row(4'b0111);
        wait_row(4'hF);
        pressed = pat;
        wait_row(4'b1110);
        check("key_state", key_state, m_stable);
        model_scan(pat);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || evt_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_pending", sb_q.size(), 0);
        check("drain_valid", evt_valid, 0);
    endtask

    // Monitor: compares and pops the head whenever popping is enabled
    initial begin
        logic [4:0] exp;
        forever begin
            @(negedge clk);
            mon_pop = 1'b0;
            if (auto_pop && evt_valid) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errs++;
                    $display("FAIL evt_unexpected: got %0h expected none", evt_data);
                end else begin
                    exp = sb_q.pop_front();
                    if (evt_data !== exp) begin
                        n_errs++;
                        $display("FAIL evt_data: got %0h expected %0h", evt_data, exp);
                    end
                end
                mon_pop = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pat;
        logic [15:0] p1;
        logic [15:0] p2;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_row_n", row_n, 4'hF);
        check("rst_key_state", key_state, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_data", evt_data, 0);
        check("rst_evt_count", evt_count, 0);
        check("rst_irq", irq, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Held press produces one event
        repeat (4) run_scan(16'h0040);
        check("press_count", evt_count, 1);
        check("press_data", evt_data, 5'b0_0110);
        check("press_key", key_state[6], 1);
        check("press_irq", irq, 1);
        auto_pop = 1'b1;
        drain();

        // Release after debounced press
        auto_pop = 1'b0;
        repeat (4) run_scan(16'h0000);
`ifdef KEYPAD_RELEASE_EVT_EN
        check("release_count", evt_count, 1);
        check("release_data", evt_data, 5'b1_0110);
`else
        check("release_count", evt_count, 0);
        check("release_key", key_state[6], 0);
`endif
        auto_pop = 1'b1;
        drain();

        // Short press is filtered out
        repeat (2) run_scan(16'h0040);
        run_scan(16'h0000);
        check("bounce_count", evt_count, 0);
        check("bounce_key", key_state, 0);

        pat = '0;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) pat[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) pat[$urandom_range(0, 15)] ^= 1'b1;
            run_scan(pat);
        end
        repeat (4) run_scan(16'h0000);
        drain();

        // Five presses into a four-entry FIFO
        auto_pop = 1'b0;
        p1 = 16'h0000;
        p1[0] = 1'b1; p1[3] = 1'b1; p1[5] = 1'b1; p1[9] = 1'b1; p1[14] = 1'b1;
        repeat (4) run_scan(p1);
        check("ovf_count", evt_count, sb_q.size());
        check("ovf_count_full", evt_count, 4);
        check("ovf_dropped", m_drop, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_head", evt_data, 5'd0);
        @(negedge clk);
        ovf_clear = 1'b1;
        @(posedge clk);
        #1 ovf_clear = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("ovf_irq", irq, 1);

        // Pop in the very cycle key 15 (row 3, col 3) is pushed into the full FIFO
        p2 = p1;
        p2[15] = 1'b1;
        repeat (2) run_scan(p2);
        check("fullpop_head", evt_data, sb_q[0]);
        void'(sb_q.pop_front());
        run_scan(p2);
        repeat (8 * 3 + 4 + 3) @(posedge clk);
        #1 man_pop = 1'b1;
        @(posedge clk);
        #1 man_pop = 1'b0;
        check("fullpop_count", evt_count, 4);
        check("fullpop_ovf", overflow, 0);
        auto_pop = 1'b1;
        drain();
        repeat (4) run_scan(16'h0000);
        drain();

        // Reset during row 2 evaluation
        auto_pop = 1'b0;
        repeat (3) run_scan(16'h0040);
        wait_row(4'b1011);
        wait_row(4'hF);
        check("pre_rst_count", evt_count, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_row_n", row_n, 4'hF);
        check("mid_rst_count", evt_count, 0);
        check("mid_rst_key", key_state, 0);
        check("mid_rst_irq", irq, 0);
        pressed = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("restart_row0", row_n, 4'b1110);
        auto_pop = 1'b1;
        repeat (3) run_scan(16'h0000);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_event_ctrl.md
KEYPAD_EVENT_CTRL -- requirements
Module: keypad_event_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 4: matrix rows, range 2..8.
REQ-002 SHALL have parameter COLS, default 4: matrix columns, range 2..8.
REQ-003 SHALL have parameter SETTLE, default 16: row-drive settle cycles before sampling, minimum 3.
REQ-004 SHALL have parameter DEBOUNCE, default 4: consecutive differing samples required to accept a change, minimum 1.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8: event buffer entries, a power of 2.
REQ-006 SHALL define derived widths KW = clog2(ROWS*COLS) and CW = clog2(FIFO_DEPTH+1).
REQ-007 clk  in  1  single clock; all logic rises on clk.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 col_n  in  COLS  matrix columns, active-low, externally pulled up, asynchronous.
REQ-010 row_n  out  ROWS  matrix row drive, active-low, one-hot-low or all-high.
REQ-011 key_state  out  ROWS*COLS  debounced pressed bitmap, bit index row*COLS+col.
REQ-012 evt_valid  out  1  FIFO non-empty.
REQ-013 evt_data  out  KW+1  FIFO head: bit KW = release flag, [KW-1:0] = key code.
REQ-014 evt_pop  in  1  consume head.
REQ-015 evt_count  out  CW  FIFO occupancy.
REQ-016 irq  out  1  level interrupt, equal to evt_valid OR overflow.
REQ-017 overflow  out  1  sticky: an event was dropped.
REQ-018 ovf_clear  in  1  clears overflow.

Function
REQ-019 col_n SHALL pass through a 2-flop synchroniser before use.
REQ-020 Scan FSM SHALL cycle DRIVE (SETTLE cycles, current row low) -> SAMPLE (1 cycle, row low, latch synchronised col_n) -> EVAL (COLS cycles, row_n all high, one column per cycle) -> DRIVE of the next row.
REQ-021 Row index SHALL wrap from ROWS-1 to 0; one full scan SHALL take ROWS*(SETTLE+1+COLS) cycles.
REQ-022 In EVAL, a sample differing from the stable state SHALL increment that key's counter, and an equal sample SHALL zero it.
REQ-023 When a counter reaches DEBOUNCE, the stable state SHALL toggle, the counter SHALL zero, and one event SHALL be generated in that same EVAL cycle.
REQ-024 At most one event SHALL be generated per cycle.
REQ-025 Press events SHALL carry release flag 0; release events SHALL carry release flag 1.
REQ-026 key_state SHALL update in the same cycle the event is generated.
REQ-027 The FIFO SHALL be show-ahead: evt_data equals the head while evt_valid=1, and equals 0 when empty.
REQ-028 evt_pop while empty SHALL be ignored.
REQ-029 A push while full with no pop SHALL drop the event and set overflow.
REQ-030 A simultaneous push and pop while full SHALL accept both, and occupancy SHALL be unchanged.
REQ-031 A simultaneous push and pop while empty SHALL write the event, and evt_valid SHALL be 1 on the next cycle.
REQ-032 ovf_clear SHALL clear overflow next cycle, and a same-cycle overflow set SHALL win over ovf_clear.

Reset
REQ-033 While rst=1: row_n all ones; FSM in DRIVE, row 0, counter 0; synchroniser, debounce counters and key_state zero; FIFO empty; evt_data, evt_count, irq and overflow zero.
REQ-034 rst asserted mid-scan SHALL abort the scan immediately, with no partial event pushed.

Configuration
REQ-035 With KEYPAD_RELEASE_EVT_EN defined, release events SHALL be pushed to the FIFO.
REQ-036 Without KEYPAD_RELEASE_EVT_EN, release events SHALL update key_state only and SHALL NOT be pushed.

Structure
REQ-037 Package keypad_pkg SHALL hold the scan-state enum (DRIVE, SAMPLE, EVAL) and the release-flag bit-position function of KW.
REQ-038 The FIFO SHALL be the sub-module keypad_evt_fifo (parameters WIDTH and DEPTH; push/pop/full/empty/count).

Verification (ROWS=4, COLS=4, SETTLE=3, DEBOUNCE=3, FIFO_DEPTH=4)
REQ-039 Hold row1/col2 pressed for 4 scans -> exactly one event, evt_data=5'b0_0110, key_state[6]=1, irq=1.
REQ-040 Press row1/col2 for 2 scans then release -> no event, key_state unchanged.
REQ-041 Release row1/col2 after a debounced press -> macro on: evt_data=5'b1_0110; macro off: no event, key_state[6]=0.
REQ-042 Debounce 5 distinct presses with no pop -> evt_count=4, overflow=1, first four codes in order; ovf_clear -> overflow=0, irq stays 1.
REQ-043 Pop on the cycle an event is pushed into a full FIFO -> evt_count stays 4, the new event is at the tail, overflow=0.
REQ-044 Assert rst during EVAL of row 2 -> row_n=4'hF, evt_count=0, key_state=0 immediately; scan restarts at row 0.
